// File: rtl/vector_dot_acc.sv
// Dot-product accumulator for the 16-lane queue: uint8 vectors x int8 weights,
// grouped over acc_len vectors, saturated to int16. Define VECTOR_DOT_RELU_EN to clamp negatives to 0.
module vector_dot_acc #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int ACCW  = 25,
  parameter int OUTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES*DW-1:0]   in_vector,
  input  logic                  in_en,
  input  logic                  w_load,
  input  logic [LANES*DW-1:0]   w_data,
  input  logic [3:0]            acc_len,
  output logic [OUTW-1:0]       out_data,
  output logic                  out_valid,
  output logic                  up_block,
  output logic                  err
);

  // Handshake: in_en is a one-cycle strobe with no ready; up_block tells the
  // queue to hold off, and any strobe arriving while draining is dropped and flagged.

  localparam int PW  = 2 * DW + 1;
  localparam int GRP = 4;
  localparam int GL  = LANES / GRP;
  localparam int SW  = PW + 2;
  localparam int TW  = PW + 4;

  localparam logic [OUTW-1:0] OMAX = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic [OUTW-1:0] OMIN = {1'b1, {(OUTW-1){1'b0}}};
  localparam logic signed [ACCW-1:0] AMAX = {{(ACCW-OUTW){1'b0}}, OMAX};
  localparam logic signed [ACCW-1:0] AMIN = {{(ACCW-OUTW){1'b1}}, OMIN};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;
  logic [3:0] len, len_nx;
  logic [3:0] count, count_nx;
  logic       accept, first_in, last_in;

  logic [DW-1:0]          weight [LANES];
  logic signed [PW-1:0]   prod_nx [LANES];
  logic signed [PW-1:0]   prod [LANES];
  logic signed [SW-1:0]   part_nx [GRP];
  logic signed [SW-1:0]   part [GRP];
  logic signed [TW-1:0]   total_nx;
  logic signed [TW-1:0]   total;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] total_ext;
  logic signed [ACCW-1:0] acc_sum;
  logic [OUTW-1:0]        res;

  logic s1_v, s1_first, s1_last;
  logic s2_v, s2_first, s2_last;
  logic s3_v, s3_first, s3_last;
  logic done;
  logic w_ok;

  function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] d, input logic [DW-1:0] w);
    logic signed [PW-1:0] de;
    logic signed [PW-1:0] we;
    de = $signed({{(PW-DW){1'b0}}, d});
    we = $signed({{(PW-DW){w[DW-1]}}, w});
    return de * we;
  endfunction

  // ---------------- control FSM ----------------
  always_comb begin
    state_nx = state;
    len_nx   = len;
    count_nx = count;
    accept   = 1'b0;
    first_in = 1'b0;
    last_in  = 1'b0;
    up_block = 1'b0;
    case (state)
      IDLE: begin
        count_nx = 4'd0;
        if (in_en) begin
          accept   = 1'b1;
          first_in = 1'b1;
          len_nx   = (acc_len == 4'd0) ? 4'd1 : acc_len;
          count_nx = 4'd1;
          if (len_nx == 4'd1) begin
            last_in  = 1'b1;
            state_nx = DRAIN;
          end else begin
            state_nx = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_en) begin
          accept   = 1'b1;
          count_nx = count + 4'd1;
          if (count_nx == len) begin
            last_in  = 1'b1;
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        up_block = 1'b1;
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len   <= 4'd0;
      count <= 4'd0;
    end else begin
      state <= state_nx;
      len   <= len_nx;
      count <= count_nx;
    end
  end

  // ---------------- weights ----------------
  assign w_ok = (state == IDLE) && !s1_v && !s2_v && !s3_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) weight[k] <= '0;
    end else if (w_load && w_ok) begin
      for (int k = 0; k < LANES; k++) weight[k] <= w_data[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if ((w_load && !w_ok) || (in_en && state == DRAIN)) err <= 1'b1;
  end

  // ---------------- datapath ----------------
  always_comb begin
    for (int k = 0; k < LANES; k++) prod_nx[k] = mul(in_vector[k*DW +: DW], weight[k]);
  end

  always_comb begin
    for (int g = 0; g < GRP; g++) begin
      part_nx[g] = '0;
      for (int j = 0; j < GL; j++)
        part_nx[g] = part_nx[g] + {{(SW-PW){prod[g*GL+j][PW-1]}}, prod[g*GL+j]};
    end
    total_nx = '0;
    for (int g = 0; g < GRP; g++)
      total_nx = total_nx + {{(TW-SW){part[g][SW-1]}}, part[g]};
  end

  assign total_ext = {{(ACCW-TW){total[TW-1]}}, total};
  assign acc_sum   = acc + total_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) prod[k] <= '0;
      for (int g = 0; g < GRP; g++) part[g] <= '0;
      total    <= '0;
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s3_v     <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
    end else begin
      for (int k = 0; k < LANES; k++) prod[k] <= prod_nx[k];
      for (int g = 0; g < GRP; g++) part[g] <= part_nx[g];
      total    <= total_nx;
      s1_v     <= accept;
      s1_first <= first_in;
      s1_last  <= last_in;
      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s3_v     <= s2_v;
      s3_first <= s2_first;
      s3_last  <= s2_last;
    end
  end

  // Saturate the final accumulator; the result register launches one cycle after the last accumulate.
  always_comb begin
    if (acc > AMAX)      res = OMAX;
    else if (acc < AMIN) res = OMIN;
    else                 res = acc[OUTW-1:0];
`ifdef VECTOR_DOT_RELU_EN
    if (acc[ACCW-1]) res = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (s3_v) acc <= s3_first ? total_ext : acc_sum;
      done      <= s3_v && s3_last;
      out_valid <= done;
      if (done) out_data <= res;
    end
  end

endmodule

// File: tb/tb_vector_dot_acc.sv
// Self-checking bench for vector_dot_acc: directed scenarios plus random groups
// checked against an integer dot-product model.
module tb_vector_dot_acc;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_vector;
  logic         in_en;
  logic         w_load;
  logic [127:0] w_data;
  logic [3:0]   acc_len;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         up_block;
  logic         err;

  int checks = 0;
  int errors = 0;
  int wm [16];
  int nw [16];
  int vecs [16][16];
  logic [15:0] exp_q [$];

  vector_dot_acc dut (
    .clk(clk), .reset(reset), .in_vector(in_vector), .in_en(in_en),
    .w_load(w_load), .w_data(w_data), .acc_len(acc_len),
    .out_data(out_data), .out_valid(out_valid), .up_block(up_block), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint dot_ref(input int i);
    longint s = 0;
    for (int k = 0; k < 16; k++) s += longint'(vecs[i][k]) * longint'(wm[k]);
    return s;
  endfunction

  function automatic logic [15:0] ref_result(input longint v);
    longint c;
    c = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
`ifdef VECTOR_DOT_RELU_EN
    if (c < 0) c = 0;
`endif
    return 16'(c);
  endfunction

  // ---------------- drivers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_nw;
    for (int k = 0; k < 16; k++) w_data[k*8 +: 8] = 8'(nw[k]);
    w_load = 1'b1;
    tick;
    w_load = 1'b0;
    for (int k = 0; k < 16; k++) wm[k] = nw[k];
  endtask

  task automatic rand_weights;
    for (int k = 0; k < 16; k++) nw[k] = int'($urandom_range(255)) - 128;
  endtask

  task automatic rand_vecs;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 16; k++) vecs[i][k] = int'($urandom_range(255));
  endtask

  // Sends one group back-to-back and observes the 8 cycles after the last accept.
  task automatic run_group(input int len_field, input bit mid_wload, input bit drain_in,
                           input bit load_first, output int ov_cnt, output int ov_k,
                           output int ub_cnt, output logic [15:0] got);
    int eff;
    longint acc;
    acc = 0;
    eff = (len_field == 0) ? 1 : len_field;
    for (int i = 0; i < eff; i++) begin
      for (int k = 0; k < 16; k++) in_vector[k*8 +: 8] = 8'(vecs[i][k]);
      acc_len = 4'(len_field);
      in_en = 1'b1;
      if (load_first && i == 0) begin
        for (int k = 0; k < 16; k++) w_data[k*8 +: 8] = 8'(nw[k]);
        w_load = 1'b1;
      end
      if (mid_wload && i == 1) begin
        w_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        w_load = 1'b1;
      end
      acc += dot_ref(i);
      tick;
      w_load = 1'b0;
      if (load_first && i == 0) for (int k = 0; k < 16; k++) wm[k] = nw[k];
    end
    exp_q.push_back(ref_result(acc));
    in_en = drain_in;
    if (drain_in) in_vector = {$urandom(), $urandom(), $urandom(), $urandom()};
    ov_cnt = 0; ov_k = -1; ub_cnt = 0; got = '0;
    for (int k = 0; k < 8; k++) begin
      if (up_block) ub_cnt++;
      if (out_valid) begin ov_cnt++; ov_k = k; got = out_data; end
      tick;
      in_en = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (up_block !== 1'b0) begin errors++; $display("FAIL reset_up_block: got %b, required 0", up_block); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
  endtask

  task automatic test_single;
    int c, kk, ub; logic [15:0] got, e;
    for (int k = 0; k < 16; k++) begin nw[k] = 1; vecs[0][k] = 10; end
    load_nw;
    run_group(1, 0, 0, 0, c, kk, ub, got);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL single_data: got %0d, required %0d", $signed(got), $signed(e)); end
    checks++; if (c !== 1 || kk !== 4) begin errors++; $display("FAIL single_timing: %0d strobes at cycle %0d, required 1 at 4", c, kk); end
    checks++; if (ub !== 4) begin errors++; $display("FAIL single_up_block: high %0d cycles, required 4", ub); end
  endtask

  task automatic test_saturate;
    int c, kk, ub; logic [15:0] got, e;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 16; k++) vecs[i][k] = 255;
    for (int k = 0; k < 16; k++) nw[k] = -128;
    load_nw;
    run_group(4, 0, 0, 0, c, kk, ub, got);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL saturate_data: got %0d, required %0d", $signed(got), $signed(e)); end
    checks++; if (c !== 1 || kk !== 4 || ub !== 4) begin errors++; $display("FAIL saturate_timing: %0d strobes at %0d, up_block %0d, required 1 at 4, 4", c, kk, ub); end
  endtask

  task automatic test_ramp;
    int c, kk, ub; logic [15:0] got, e;
    for (int k = 0; k < 16; k++) begin nw[k] = k - 8; vecs[0][k] = k; vecs[1][k] = 1; end
    load_nw;
    run_group(2, 0, 0, 0, c, kk, ub, got);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL ramp_data: got %0d, required %0d", $signed(got), $signed(e)); end
    checks++; if (c !== 1 || kk !== 4) begin errors++; $display("FAIL ramp_timing: %0d strobes at %0d, required 1 at 4", c, kk); end
  endtask

  task automatic test_len_zero;
    int c, kk, ub; logic [15:0] got, e;
    for (int k = 0; k < 16; k++) begin nw[k] = 2; vecs[0][k] = 3; end
    load_nw;
    run_group(0, 0, 0, 0, c, kk, ub, got);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL len_zero_data: got %0d, required %0d", $signed(got), $signed(e)); end
    checks++; if (c !== 1 || kk !== 4 || ub !== 4) begin errors++; $display("FAIL len_zero_timing: %0d strobes at %0d, up_block %0d, required 1 at 4, 4", c, kk, ub); end
  endtask

  task automatic test_load_with_vector;
    int c, kk, ub; logic [15:0] got, e;
    rand_weights; load_nw;
    rand_vecs; rand_weights;
    run_group(2, 0, 0, 1, c, kk, ub, got);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL load_with_vector_data: got %0d, required %0d", $signed(got), $signed(e)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_with_vector_err: got %b, required 0", err); end
  endtask

  task automatic test_random;
    int c, kk, ub, len; logic [15:0] got, e;
    for (int n = 0; n < 8; n++) begin
      rand_weights; load_nw; rand_vecs;
      len = int'($urandom_range(15));
      run_group(len, 0, 0, 0, c, kk, ub, got);
      e = exp_q.pop_front();
      checks++; if (got !== e || c !== 1 || kk !== 4) begin
        errors++; $display("FAIL random_group%0d: len %0d got %0d (%0d strobes at %0d), required %0d (1 at 4)", n, len, $signed(got), c, kk, $signed(e));
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL random_err: got %b, required 0", err); end
  endtask

  task automatic test_errors;
    int c, kk, ub; logic [15:0] got, e;
    rand_weights; load_nw; rand_vecs;
    run_group(3, 1, 1, 0, c, kk, ub, got);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL errors_data: got %0d, required %0d", $signed(got), $signed(e)); end
    checks++; if (c !== 1 || kk !== 4 || ub !== 4) begin errors++; $display("FAIL errors_timing: %0d strobes at %0d, up_block %0d, required 1 at 4, 4", c, kk, ub); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL errors_err: got %b, required 1", err); end
    rand_vecs;
    run_group(2, 0, 0, 0, c, kk, ub, got);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL errors_weights_kept: got %0d, required %0d", $signed(got), $signed(e)); end
  endtask

  task automatic test_reset_mid;
    int c, kk, ub, seen; logic [15:0] got, e;
    for (int k = 0; k < 16; k++) nw[k] = 5;
    load_nw; rand_vecs;
    for (int k = 0; k < 16; k++) in_vector[k*8 +: 8] = 8'(vecs[0][k]);
    acc_len = 4'd1;
    in_en = 1'b1;
    tick;
    in_en = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      tick;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_valid: %0d strobes, required 0", seen); end
    checks++; if (err !== 1'b0 || out_data !== 16'd0) begin errors++; $display("FAIL reset_mid_state: err %b out_data %0d, required 0 0", err, out_data); end
    for (int k = 0; k < 16; k++) wm[k] = 0;
    rand_vecs;
    run_group(3, 0, 0, 0, c, kk, ub, got);
    e = exp_q.pop_front();
    checks++; if (got !== e || c !== 1) begin errors++; $display("FAIL reset_mid_zero_weights: got %0d (%0d strobes), required %0d (1)", $signed(got), c, $signed(e)); end
  endtask

  initial begin
    reset = 1'b1; in_en = 1'b0; w_load = 1'b0;
    in_vector = '0; w_data = '0; acc_len = 4'd0;
    test_reset;
    test_single;
    test_saturate;
    test_ramp;
    test_len_zero;
    test_load_with_vector;
    test_random;
    test_errors;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
